morph_program_runner: RTL and testbench

Sequential controller that runs a short program of morphological steps on one binary image. It sits directly around the combinational morphologic unit. It latches an input image and a packed program of (op, structuring element) steps, then drives the unit's `img`/`el`/`op` inputs one step per clock. It feeds each `result` back as the next step's image and finally presents the processed image with a done pulse. It is the evaluation stage that turns a genetic chromosome (step list) into a filtered image.

---
 rtl/morph_program_runner.sv | 101 ++++++++++
 tb/tb_morph_program_runner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_program_runner.sv
// Runs a short program of (op, structuring element) steps through an external
// combinational morphologic unit, feeding each step's result back as the next image.
module morph_program_runner #(
    parameter int ImageWidth  = 8,
    parameter int ImageHeight = 4,
    parameter int MaxSteps    = 4,
    parameter int LenWidth    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ImageWidth*ImageHeight-1:0]  img_in,
    input  logic [12*MaxSteps-1:0]             program_bits,
    input  logic [LenWidth-1:0]                length,
    output logic [ImageWidth*ImageHeight-1:0]  unit_img,
    output logic [8:0]                         unit_el,
    output logic [2:0]                         unit_op,
    input  logic [ImageWidth*ImageHeight-1:0]  unit_result,
    output logic                               busy,
    output logic                               done,
    output logic [ImageWidth*ImageHeight-1:0]  result,
    output logic [LenWidth-1:0]                step,
    output logic [1:0]                         fsm_state
);

    localparam int Pixels = ImageWidth * ImageHeight;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [Pixels-1:0]     work;
    logic [12*MaxSteps-1:0] prog;
    logic [LenWidth-1:0]   len;
    logic [LenWidth-1:0]   eff_len;
    logic [11:0]           cur_step;

    // Protocol: start is a request taken only in IDLE (no ready signal, no queueing);
    // done is a one-cycle strobe marking result valid, and result holds until the next done.
    assign eff_len = (length > LenWidth'(MaxSteps)) ? LenWidth'(MaxSteps) : length;

    always_comb begin
        cur_step = '0;
        for (int k = 0; k < MaxSteps; k++) begin
            if (step == LenWidth'(k)) begin
                cur_step = prog[12*k +: 12];
            end
        end
    end

    assign unit_img             = work;
    assign {unit_op, unit_el}   = cur_step;
    assign busy                 = (state == RUN);
    assign done                 = (state == DONE);
    assign fsm_state            = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            prog   <= '0;
            len    <= '0;
            step   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= img_in;
                        prog <= program_bits;
                        step <= '0;
                        len  <= eff_len;
                        // An empty program completes immediately with the source image.
                        if (eff_len == '0) begin
                            result <= img_in;
                            state  <= DONE;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    work <= unit_result;
                    if (step == len - LenWidth'(1)) begin
                        result <= unit_result;
                        state  <= DONE;
                    end else begin
                        step <= step + LenWidth'(1);
                    end
                end
                DONE: begin
                    step  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morph_program_runner.sv
// Directed bench for morph_program_runner with a stub unit: bitwise inversion,
// or a small erode/dilate reference stand-in for the morphologic unit.
module tb_morph_program_runner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] img_in;
    logic [47:0] program_bits;
    logic [2:0]  length;
    logic [31:0] unit_img;
    logic [8:0]  unit_el;
    logic [2:0]  unit_op;
    logic [31:0] unit_result;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  step;
    logic [1:0]  fsm_state;

    logic        stub_morph;
    int          errors;
    int          checks;

    morph_program_runner dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .img_in       (img_in),
        .program_bits (program_bits),
        .length       (length),
        .unit_img     (unit_img),
        .unit_el      (unit_el),
        .unit_op      (unit_op),
        .unit_result  (unit_result),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .step         (step),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel (r,c) is bit r*8+c; element bit 8 is top-left, bit 4 the centre.
    function automatic logic [31:0] morph(input logic [31:0] img, input logic [8:0] el,
                                          input logic dil);
        logic [31:0] o;
        logic        acc;
        logic        p;
        int          rr;
        int          cc;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                acc = !dil;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (el[8 - ((dr + 1) * 3 + (dc + 1))]) begin
                            rr = r + dr;
                            cc = c + dc;
                            p = (rr >= 0 && rr < 4 && cc >= 0 && cc < 8) ? img[rr*8 + cc] : 1'b0;
                            acc = dil ? (acc | p) : (acc & p);
                        end
                    end
                end
                o[r*8 + c] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] unit_model(input logic [31:0] img, input logic [8:0] el,
                                               input logic [2:0] op);
        logic [31:0] t;
        t = morph(img, el, op[0]);
        if (op[1]) t = morph(t, el, !op[0]);
        return t;
    endfunction

    always_comb begin
        unit_result = ~unit_img;
        if (stub_morph) unit_result = unit_model(unit_img, unit_el, unit_op);
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one program, scramble inputs after the start edge, then follow it to done.
    task automatic run_prog(input string tag, input logic [31:0] img, input logic [47:0] pg,
                            input logic [2:0] len_in, input int exp_l, input logic [31:0] exp_res);
        int lat;
        int bcnt;
        img_in       = img;
        program_bits = pg;
        length       = len_in;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        img_in       = $urandom();
        program_bits = 48'({$urandom(), $urandom()});
        length       = 3'($urandom_range(0, 7));
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) begin
                check({tag, " step"}, 64'(step), 64'(bcnt));
                check({tag, " op/el"}, 64'({unit_op, unit_el}), 64'(pg[12*bcnt +: 12]));
                bcnt++;
            end
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_l + 1));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(exp_l));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        tick();
        check({tag, " done single"}, 64'(done), 64'(0));
        check({tag, " result held"}, 64'(result), 64'(exp_res));
    endtask

    // ---------------- directed sequence ----------------
    logic [47:0] seq_prog;
    int          lat1;
    int          gap;
    int          bgap;

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        img_in       = '0;
        program_bits = '0;
        length       = '0;
        stub_morph   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst step", 64'(step), 64'(0));
        check("rst result", 64'(result), 64'(0));
        check("rst unit_img", 64'(unit_img), 64'(0));
        check("rst unit_el/op", 64'({unit_op, unit_el}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle done", 64'(done), 64'(0));
            check("idle busy", 64'(busy), 64'(0));
        end

        // Reset in the middle of a 4-step run, at step 2.
        img_in       = 32'h1234_5678;
        program_bits = 48'hABC_DEF_123_456;
        length       = 3'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrun step", 64'(step), 64'(2));
        check("midrun busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort state", 64'(fsm_state), 64'(0));
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort step", 64'(step), 64'(0));
        check("abort result", 64'(result), 64'(0));
        check("abort unit_img", 64'(unit_img), 64'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort no done", 64'(done), 64'(0));
        end

        // Inversion stub: odd step counts invert, even counts restore.
        run_prog("inv L3", 32'h0008_1000, 48'h111_222_333_444, 3'd3, 3, 32'hFFF7_EFFF);
        run_prog("inv L2", 32'h0008_1000, 48'h5A5_0F0_777_888, 3'd2, 2, 32'h0008_1000);
        run_prog("inv L0", 32'h0008_1000, 48'h999_AAA_BBB_CCC, 3'd0, 0, 32'h0008_1000);

        // Step k carries op=k, el=9'h1F0+k; length 7 clamps to 4.
        for (int k = 0; k < 4; k++) seq_prog[12*k +: 12] = {3'(k), 9'h1F0 + 9'(k)};
        run_prog("seq clamp", 32'hA5A5_0F0F, seq_prog, 3'd7, 4, 32'hA5A5_0F0F);
        run_prog("seq L4", 32'h0000_FFFF, seq_prog, 3'd4, 4, 32'h0000_FFFF);
        run_prog("seq L1", 32'h8000_0001, seq_prog, 3'd1, 1, 32'h7FFF_FFFE);

        // start held high: one run, then the next only from the first IDLE cycle.
        img_in       = 32'hF0F0_F0F0;
        program_bits = 48'h123_123_123_123;
        length       = 3'd2;
        start        = 1'b1;
        tick();
        lat1 = 1;
        while (done !== 1'b1 && lat1 < 20) begin
            tick();
            lat1++;
        end
        check("hold first latency", 64'(lat1), 64'(3));
        check("hold first result", 64'(result), 64'(32'hF0F0_F0F0));
        tick();
        check("hold idle gap busy", 64'(busy), 64'(0));
        gap  = 1;
        bgap = 0;
        while (done !== 1'b1 && gap < 20) begin
            if (busy === 1'b1) bgap++;
            tick();
            gap++;
        end
        start = 1'b0;
        check("hold done spacing", 64'(gap), 64'(4));
        check("hold second busy", 64'(bgap), 64'(2));
        tick();
        tick();
        check("hold released", 64'(busy), 64'(0));

        // Reference unit, single pixel and centre-only element: identity for every op.
        stub_morph = 1'b1;
        for (int op = 0; op < 8; op++) begin
            run_prog($sformatf("centre op%0d", op), 32'h0000_0800,
                     48'({3'(op), 9'b000010000}), 3'd1, 1, 32'h0000_0800);
        end
        // Full 3x3 element does change the image, so the stub is live.
        run_prog("box dilate", 32'h0000_0800, 48'({3'd1, 9'h1FF}), 3'd1, 1, 32'h001C_1C1C);
        stub_morph = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
